// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default geometry, instruction codes.
// Pure declarations, no logic.
package jtag_pkg;

   localparam int          DEF_IR_WIDTH   = 4;
   localparam logic [31:0] DEF_IDCODE_VAL = 32'h0BA0_0477;

   localparam logic [3:0] EXTEST = 4'b0000;
   localparam logic [3:0] SAMPLE = 4'b0001;
   localparam logic [3:0] IDCODE = 4'b0010;
   localparam logic [3:0] BYPASS = 4'b1111;

   typedef enum logic [3:0] {
      TLR,
      RTI,
      SEL_DR,
      CAP_DR,
      SHIFT_DR,
      EXIT1_DR,
      PAUSE_DR,
      EXIT2_DR,
      UPD_DR,
      SEL_IR,
      CAP_IR,
      SHIFT_IR,
      EXIT1_IR,
      PAUSE_IR,
      EXIT2_IR,
      UPD_IR
   } tap_state_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP sequencer driven by tms; one-hot decodes come straight off the
// state register (Moore, valid the cycle the state is entered, no backpressure).
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic tck,
   input  logic rst,
   input  logic tms,
   output logic st_tlr,
   output logic st_cap_dr,
   output logic st_shift_dr,
   output logic st_upd_dr,
   output logic st_cap_ir,
   output logic st_shift_ir,
   output logic st_upd_ir
);

   tap_state_t state;
   tap_state_t state_nxt;

   always_ff @(posedge tck) begin
      if (rst) begin
         state <= TLR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      st_tlr      = (state == TLR);
      st_cap_dr   = (state == CAP_DR);
      st_shift_dr = (state == SHIFT_DR);
      st_upd_dr   = (state == UPD_DR);
      st_cap_ir   = (state == CAP_IR);
      st_shift_ir = (state == SHIFT_IR);
      st_upd_ir   = (state == UPD_IR);
      case (state)
         TLR:      state_nxt = tms ? TLR      : RTI;
         RTI:      state_nxt = tms ? SEL_DR   : RTI;
         SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: state_nxt = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_nxt = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: state_nxt = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
         SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
         CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: state_nxt = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_nxt = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: state_nxt = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
         default:  state_nxt = TLR;
      endcase
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, IDCODE and bypass registers, tdo return mux and BSC strobes.
// Controls are Moore decodes of the TAP state; tdo is combinational; no backpressure.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH   = DEF_IR_WIDTH,
   parameter logic [31:0] IDCODE_VAL = DEF_IDCODE_VAL,
   parameter int          BSR_LEN    = 8
) (
   input  logic                tck,
   input  logic                rst,
   input  logic                tms,
   input  logic                tdi,
   output logic                tdo,
   output logic                tdo_en,
   output logic                bsr_si,
   input  logic                bsr_so,
   output logic                bsr_sdr,
   output logic                bsr_clk_dr,
   output logic                bsr_up_dr,
   output logic                bsr_mode,
   output logic [IR_WIDTH-1:0] ir_out
);

   localparam logic [IR_WIDTH-1:0] I_EXTEST  = IR_WIDTH'(EXTEST);
   localparam logic [IR_WIDTH-1:0] I_SAMPLE  = IR_WIDTH'(SAMPLE);
   localparam logic [IR_WIDTH-1:0] I_IDCODE  = IR_WIDTH'(IDCODE);
   localparam logic [IR_WIDTH-1:0] IR_CAPVAL = IR_WIDTH'(2'b01);

   // The capture pattern needs two IR bits and IDCODE bit0 marks a real IDCODE.
   if (IR_WIDTH < 2 || BSR_LEN < 1 || IDCODE_VAL[0] != 1'b1) begin : g_param_err
      $error("jtag_tap_ctrl: illegal parameterisation");
   end

   logic                st_tlr;
   logic                st_cap_dr;
   logic                st_shift_dr;
   logic                st_upd_dr;
   logic                st_cap_ir;
   logic                st_shift_ir;
   logic                st_upd_ir;
   logic [IR_WIDTH-1:0] ir;
   logic [IR_WIDTH-1:0] ir_sr;
   logic [31:0]         id_sr;
   logic                byp;
   logic                bsr_sel;
   logic                id_sel;

   jtag_tap_fsm u_fsm (
      .tck         (tck),
      .rst         (rst),
      .tms         (tms),
      .st_tlr      (st_tlr),
      .st_cap_dr   (st_cap_dr),
      .st_shift_dr (st_shift_dr),
      .st_upd_dr   (st_upd_dr),
      .st_cap_ir   (st_cap_ir),
      .st_shift_ir (st_shift_ir),
      .st_upd_ir   (st_upd_ir)
   );

   // Unlisted codes fall through to bypass: neither BSR nor IDCODE selected.
   assign bsr_sel = (ir == I_EXTEST) || (ir == I_SAMPLE);
   assign id_sel  = (ir == I_IDCODE);

   always_ff @(posedge tck) begin
      if (rst) begin
         ir    <= I_IDCODE;
         ir_sr <= '0;
         id_sr <= IDCODE_VAL;
         byp   <= 1'b0;
      end else begin
         if (st_tlr) begin
            ir <= I_IDCODE;
         end else if (st_upd_ir) begin
            ir <= ir_sr;
         end

         if (st_cap_ir) begin
            ir_sr <= IR_CAPVAL;
         end else if (st_shift_ir) begin
            ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
         end

         if (st_cap_dr && id_sel) begin
            id_sr <= IDCODE_VAL;
         end else if (st_shift_dr && id_sel) begin
            id_sr <= {tdi, id_sr[31:1]};
         end

         if (st_cap_dr && !id_sel && !bsr_sel) begin
            byp <= 1'b0;
         end else if (st_shift_dr && !id_sel && !bsr_sel) begin
            byp <= tdi;
         end
      end
   end

   always_comb begin
      tdo = 1'b0;
      if (st_shift_ir) begin
         tdo = ir_sr[0];
      end else if (st_shift_dr) begin
         if (id_sel) begin
            tdo = id_sr[0];
         end else if (bsr_sel) begin
            tdo = bsr_so;
         end else begin
            tdo = byp;
         end
      end
   end

   assign tdo_en     = st_shift_dr || st_shift_ir;
   assign bsr_si     = tdi;
   assign bsr_sdr    = st_shift_dr && bsr_sel;
   assign bsr_clk_dr = (st_cap_dr || st_shift_dr) && bsr_sel;
   assign bsr_up_dr  = st_upd_dr && bsr_sel;
   assign bsr_mode   = (ir == I_EXTEST);
   assign ir_out     = ir;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed TAP scenarios plus a randomized tms/tdi run against a table-driven model.
module tb_jtag_tap_ctrl;

   localparam logic [31:0] IDV = 32'h0BA0_0477;

   localparam int S_TLR = 0, S_RTI = 1, S_SDR = 2, S_CDR = 3, S_SHDR = 4, S_E1DR = 5,
                  S_PDR = 6, S_E2DR = 7, S_UDR = 8, S_SIR = 9, S_CIR = 10, S_SHIR = 11,
                  S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

   // next state for tms=0 and tms=1, straight from the TAP diagram
   int nxt0 [16] = '{S_RTI, S_RTI, S_CDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
                     S_RTI, S_CIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
   int nxt1 [16] = '{S_TLR, S_SDR, S_SIR, S_E1DR, S_E1DR, S_UDR, S_E2DR, S_UDR,
                     S_SDR, S_TLR, S_E1IR, S_E1IR, S_UIR, S_E2IR, S_UIR, S_SDR};

   logic       tck = 1'b0;
   logic       rst = 1'b1;
   logic       tms = 1'b1;
   logic       tdi = 1'b0;
   logic       tdo, tdo_en, bsr_si, bsr_so, bsr_sdr, bsr_clk_dr, bsr_up_dr, bsr_mode;
   logic [3:0] ir_out;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int          m_st;
   logic [3:0]  m_ir, m_irsr;
   logic [31:0] m_id;
   logic        m_byp;

   // samples taken before each edge, and the model's prediction for them
   logic       o_tdo, o_en, o_sdr, o_clk, o_up, o_mode;
   logic [3:0] o_ir;
   logic [10:0] o_vec, e_vec;

   // 8-cell boundary-scan chain fixture
   logic [7:0] chain = 8'h00;
   logic [7:0] pins  = 8'h00;
   int         up_cnt = 0;

   always #5 tck = ~tck;

   assign bsr_so = chain[0];

   always @(posedge tck) begin
      if (bsr_clk_dr) chain <= bsr_sdr ? {bsr_si, chain[7:1]} : pins;
      if (bsr_up_dr) up_cnt <= up_cnt + 1;
   end

   jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(IDV), .BSR_LEN(8)) dut (
      .tck        (tck),
      .rst        (rst),
      .tms        (tms),
      .tdi        (tdi),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .bsr_si     (bsr_si),
      .bsr_so     (bsr_so),
      .bsr_sdr    (bsr_sdr),
      .bsr_clk_dr (bsr_clk_dr),
      .bsr_up_dr  (bsr_up_dr),
      .bsr_mode   (bsr_mode),
      .ir_out     (ir_out)
   );

   // One tck cycle: drive, sample the pre-edge outputs, predict them, advance the model.
   task automatic tick(input logic t_tms, input logic t_tdi);
      logic bsel, isel, e_tdo;
      @(negedge tck);
      tms = t_tms;
      tdi = t_tdi;
      #1;
      o_tdo = tdo; o_en = tdo_en; o_sdr = bsr_sdr; o_clk = bsr_clk_dr;
      o_up = bsr_up_dr; o_mode = bsr_mode; o_ir = ir_out;
      o_vec = {tdo, tdo_en, bsr_si, bsr_sdr, bsr_clk_dr, bsr_up_dr, bsr_mode, ir_out};
      bsel = (m_ir == 4'd0) || (m_ir == 4'd1);
      isel = (m_ir == 4'd2);
      if (m_st == S_SHIR)      e_tdo = m_irsr[0];
      else if (m_st == S_SHDR) e_tdo = isel ? m_id[0] : (bsel ? bsr_so : m_byp);
      else                     e_tdo = 1'b0;
      e_vec = {e_tdo, (m_st == S_SHIR) || (m_st == S_SHDR), t_tdi,
               (m_st == S_SHDR) && bsel, ((m_st == S_CDR) || (m_st == S_SHDR)) && bsel,
               (m_st == S_UDR) && bsel, m_ir == 4'd0, m_ir};
      @(posedge tck);
      if (rst) begin
         m_st = S_TLR; m_ir = 4'd2; m_irsr = 4'd0; m_id = IDV; m_byp = 1'b0;
      end else begin
         case (m_st)
            S_TLR:  m_ir = 4'd2;
            S_CIR:  m_irsr = 4'b0001;
            S_SHIR: m_irsr = {t_tdi, m_irsr[3:1]};
            S_UIR:  m_ir = m_irsr;
            S_CDR:  begin
                       if (isel) m_id = IDV;
                       if (!isel && !bsel) m_byp = 1'b0;
                    end
            S_SHDR: begin
                       if (isel) m_id = {t_tdi, m_id[31:1]};
                       if (!isel && !bsel) m_byp = t_tdi;
                    end
            default: ;
         endcase
         m_st = t_tms ? nxt1[m_st] : nxt0[m_st];
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b1, 1'b0);
      rst = 1'b0;
   endtask

   // From RTI, load val through the IR column and return to RTI; cap gets the SHIFT_IR tdo bits.
   task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(i == 3, val[i]);
         cap[i] = o_tdo;
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      rst = 1'b0;
      tick(1'b1, 1'b0);
      n_chk++;
      if (o_ir !== 4'b0010) begin
         n_fail++; $display("FAIL reset_ir: got %b want 0010", o_ir);
      end
      n_chk++;
      if ({o_sdr, o_clk, o_up, o_mode, o_tdo, o_en} !== 6'b0) begin
         n_fail++; $display("FAIL reset_outs: got %b want 000000", {o_sdr, o_clk, o_up, o_mode, o_tdo, o_en});
      end
      tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      n_chk++;
      if (o_en !== 1'b1) begin
         n_fail++; $display("FAIL reach_shift_dr: tdo_en got %b want 1", o_en);
      end
      for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)));
      tick(1'b1, 1'b0);
      n_chk++;
      if ({o_ir, o_sdr, o_clk, o_up, o_mode, o_en} !== {4'b0010, 5'b0}) begin
         n_fail++; $display("FAIL tms5_to_tlr: ir/sdr/clk/up/mode/en got %b want 001000000",
                            {o_ir, o_sdr, o_clk, o_up, o_mode, o_en});
      end
   endtask

   task automatic test_idcode();
      logic [31:0] word;
      int en_cnt;
      en_cnt = 0;
      do_reset();
      tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         tick(i == 31, 1'b0);
         word[i] = o_tdo;
         en_cnt += int'(o_en);
      end
      n_chk++;
      if (word !== IDV) begin
         n_fail++; $display("FAIL idcode_word: got %h want %h", word, IDV);
      end
      n_chk++;
      if (en_cnt != 32) begin
         n_fail++; $display("FAIL idcode_tdo_en: high %0d cycles want 32", en_cnt);
      end
      tick(1'b1, 1'b0);
      n_chk++;
      if ({o_tdo, o_en} !== 2'b00) begin
         n_fail++; $display("FAIL exit1_tdo: tdo/en got %b want 00", {o_tdo, o_en});
      end
      tick(1'b0, 1'b0);
   endtask

   task automatic test_bypass();
      logic [3:0] cap;
      logic [7:0] d;
      logic [8:0] got;
      d = 8'hA5;
      do_reset();
      tick(1'b0, 1'b0);
      load_ir(4'b1111, cap);
      n_chk++;
      if (cap !== 4'b0001) begin
         n_fail++; $display("FAIL ir_capture: got %b want 0001 (lsb first 1,0,0,0)", cap);
      end
      tick(1'b1, 1'b0);
      n_chk++;
      if (o_ir !== 4'b1111) begin
         n_fail++; $display("FAIL ir_bypass_load: got %b want 1111", o_ir);
      end
      tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick(i == 8, (i < 8) ? d[i] : 1'b0);
         got[i] = o_tdo;
      end
      n_chk++;
      if (got !== {d, 1'b0}) begin
         n_fail++; $display("FAIL bypass_delay: got %b want %b", got, {d, 1'b0});
      end
      tick(1'b1, 1'b0); tick(1'b0, 1'b0);
   endtask

   task automatic test_extest();
      logic [3:0] cap;
      int both, ups;
      both = 0;
      ups  = 0;
      do_reset();
      tick(1'b0, 1'b0);
      load_ir(4'b0000, cap);
      tick(1'b1, 1'b0);
      n_chk++;
      if ({o_mode, o_ir} !== 5'b1_0000) begin
         n_fail++; $display("FAIL extest_mode: mode/ir got %b want 10000", {o_mode, o_ir});
      end
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      n_chk++;
      if ({o_clk, o_sdr} !== 2'b10) begin
         n_fail++; $display("FAIL extest_capture: clk_dr/sdr got %b want 10", {o_clk, o_sdr});
      end
      for (int i = 0; i < 8; i++) begin
         tick(i == 7, 1'($urandom_range(0, 1)));
         if (o_sdr === 1'b1 && o_clk === 1'b1) both++;
         ups += int'(o_up);
      end
      n_chk++;
      if (both != 8) begin
         n_fail++; $display("FAIL extest_shift: sdr&clk_dr high %0d cycles want 8", both);
      end
      tick(1'b1, 1'b0);
      ups += int'(o_up);
      tick(1'b0, 1'b0);
      n_chk++;
      if (o_up !== 1'b1) begin
         n_fail++; $display("FAIL extest_upd: up_dr in UPD_DR got %b want 1", o_up);
      end
      ups += int'(o_up);
      tick(1'b0, 1'b0);
      ups += int'(o_up);
      n_chk++;
      if (ups != 1) begin
         n_fail++; $display("FAIL extest_up_width: up_dr high %0d cycles want 1", ups);
      end
   endtask

   task automatic test_sample_pause();
      logic [3:0]  cap;
      logic [15:0] s, got;
      int          clk_seen, mode_seen;
      clk_seen  = 0;
      mode_seen = 0;
      pins = 8'($urandom);
      s    = 16'($urandom);
      do_reset();
      tick(1'b0, 1'b0);
      load_ir(4'b0001, cap);
      tick(1'b1, 1'b0);
      n_chk++;
      if (o_mode !== 1'b0) begin
         n_fail++; $display("FAIL sample_mode: got %b want 0", o_mode);
      end
      tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick(k == 4, s[k]);
         got[k] = o_tdo;
      end
      tick(1'b0, 1'($urandom_range(0, 1)));
      for (int j = 0; j < 4; j++) begin
         tick(j == 3, 1'($urandom_range(0, 1)));
         clk_seen  += int'(o_clk);
         mode_seen += int'(o_mode);
      end
      n_chk++;
      if (clk_seen != 0 || mode_seen != 0) begin
         n_fail++; $display("FAIL pause_clk_dr: clk_dr %0d mode %0d cycles want 0 0", clk_seen, mode_seen);
      end
      tick(1'b0, 1'($urandom_range(0, 1)));
      for (int k = 5; k < 16; k++) begin
         tick(k == 15, s[k]);
         got[k] = o_tdo;
      end
      n_chk++;
      if (got !== {s[7:0], pins}) begin
         n_fail++; $display("FAIL sample_stream: got %h want %h", got, {s[7:0], pins});
      end
      tick(1'b1, 1'b0); tick(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_shift();
      int ir_bad;
      ir_bad = 0;
      do_reset();
      tick(1'b0, 1'b0);
      up_cnt = 0;
      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      rst = 1'b1;
      tick(1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0);
         if (o_ir !== 4'b0010) ir_bad++;
      end
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      if (o_ir !== 4'b0010) ir_bad++;
      n_chk++;
      if (ir_bad != 0) begin
         n_fail++; $display("FAIL rst_mid_shift_ir: ir_out wrong %0d cycles want 0 (last %b)", ir_bad, o_ir);
      end
      n_chk++;
      if (up_cnt != 0) begin
         n_fail++; $display("FAIL rst_mid_shift_up: up_dr pulses %0d want 0", up_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 80) == 0);
         if ($urandom_range(0, 15) == 0) pins = 8'($urandom);
         tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
         n_chk++;
         if (o_vec !== e_vec) begin
            n_fail++;
            $display("FAIL random_step %0d: tdo,en,si,sdr,clk,up,mode,ir got %b want %b", i, o_vec, e_vec);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idcode();
      test_bypass();
      test_extest();
      test_sample_pause();
      test_reset_mid_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
